// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: register-file geometry and index/word types.
package cpu_defs_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = $clog2(NUM_REGS);

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the register file + scoreboard.
// master = ID/WB pipeline side, slave = reg_file_sb.
interface reg_file_sb_if;
  import cpu_defs_pkg::*;

  reg_idx_t              raddr1;
  reg_idx_t              raddr2;
  word_t                 rdata1;
  word_t                 rdata2;
  logic                  issue_valid;
  reg_idx_t              issue_rd;
  logic                  hazard;
  logic                  issue_ok;
  logic                  we;
  reg_idx_t              waddr;
  word_t                 wdata;
  logic [NUM_REGS-1:0]   busy_vec;

  modport master (
    output raddr1, raddr2, issue_valid, issue_rd, we, waddr, wdata,
    input  rdata1, rdata2, hazard, issue_ok, busy_vec
  );

  modport slave (
    input  raddr1, raddr2, issue_valid, issue_rd, we, waddr, wdata,
    output rdata1, rdata2, hazard, issue_ok, busy_vec
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-writer scoreboard: one busy bit per register, RAW/WAW hazard detect.
// Optional macro REGFILE_BYPASS_EN: a register being written back this cycle
// is treated as no longer busy, so its consumer can issue in the same cycle.
module reg_scoreboard
  import cpu_defs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  reg_idx_t            issue_rd,
  input  reg_idx_t            raddr1,
  input  reg_idx_t            raddr2,
  input  logic                we,
  input  reg_idx_t            waddr,
  output logic                hazard,
  output logic                issue_ok,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] eff_busy;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;

  // Hazard detection and next busy state; a set beats a clear on the same index.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (we) begin
      clr_mask = NUM_REGS'(1) << waddr;
    end
`ifdef REGFILE_BYPASS_EN
    eff_busy = busy & ~clr_mask;
`else
    eff_busy = busy;
`endif
    hazard   = issue_valid & (eff_busy[raddr1] | eff_busy[raddr2] | eff_busy[issue_rd]);
    issue_ok = issue_valid & ~hazard;
    if (issue_ok && (issue_rd != '0)) begin
      set_mask = NUM_REGS'(1) << issue_rd;
    end
    busy_nxt = (busy & ~clr_mask) | set_mask;
  end

  // Busy-bit register; bit 0 can never be set because r0 is never reserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file (r0 hardwired to zero) with issue scoreboard.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding from the
// writeback port to both combinational read ports.
module reg_file_sb
  import cpu_defs_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  reg_file_sb_if.slave  bus
);

  word_t regs [NUM_REGS];

  // Register storage; writes to r0 are dropped so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.we && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight writeback.
  always_comb begin
    bus.rdata1 = regs[bus.raddr1];
    bus.rdata2 = regs[bus.raddr2];
`ifdef REGFILE_BYPASS_EN
    if (bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
    end
    if (bus.we && (bus.waddr != '0) && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
    end
`endif
    if (bus.raddr1 == '0) begin
      bus.rdata1 = '0;
    end
    if (bus.raddr2 == '0) begin
      bus.rdata2 = '0;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .raddr1      (bus.raddr1),
    .raddr2      (bus.raddr2),
    .we          (bus.we),
    .waddr       (bus.waddr),
    .hazard      (bus.hazard),
    .issue_ok    (bus.issue_ok),
    .busy_vec    (bus.busy_vec)
  );

endmodule
